// File: rtl/dec_sel_pkg.sv
// dec_sel_pkg: shared types, sweep-order tables and sel bit-order helper for dec_sel_sequencer.
//   Optional feature macro DEC_SEL_GRAY_EN selects the Gray sweep table instead of binary.
package dec_sel_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    // Position-to-line tables; element [p] is the decoder line visited at sweep position p.
    localparam logic [7:0][2:0] BIN_ORDER  = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [7:0][2:0] GRAY_ORDER = {3'd4, 3'd5, 3'd7, 3'd6, 3'd2, 3'd3, 3'd1, 3'd0};

`ifdef DEC_SEL_GRAY_EN
    localparam logic [7:0][2:0] SWEEP_ORDER = GRAY_ORDER;
`else
    localparam logic [7:0][2:0] SWEEP_ORDER = BIN_ORDER;
`endif

    // The decoder takes its code MSB-first on sel[0], so the index bits are mirrored.
    function automatic logic [2:0] idx_to_sel(input logic [2:0] idx);
        return {idx[0], idx[1], idx[2]};
    endfunction

endpackage

// File: rtl/dec_sel_next_pos.sv
// dec_sel_next_pos: combinational finder of the next enabled sweep position.
//   pos      in  3  current sweep position
//   dir      in  1  0 = step upward through positions, 1 = step downward
//   pmask    in  8  enable per sweep position (mask already permuted into sweep order)
//   next_pos out 3  next enabled position, wrapping around; equals pos if it is the only one
//   wrap     out 1  the step to next_pos crosses the end of the table (end of a sweep)
module dec_sel_next_pos (
    input  logic [2:0] pos,
    input  logic       dir,
    input  logic [7:0] pmask,
    output logic [2:0] next_pos,
    output logic       wrap
);

    logic [2:0] cand;
    logic       found;

    // Scan distances 1..8; distance 8 lands back on pos, covering the single-enable case.
    always_comb begin
        next_pos = pos;
        wrap     = 1'b0;
        found    = 1'b0;
        cand     = pos;
        for (int k = 1; k <= 8; k++) begin
            cand = dir ? pos - k[2:0] : pos + k[2:0];
            if (!found && pmask[cand]) begin
                found    = 1'b1;
                next_pos = cand;
                wrap     = dir ? (cand >= pos) : (cand <= pos);
            end
        end
    end

endmodule

// File: rtl/dec_sel_sequencer.sv
// dec_sel_sequencer: steps a 3-to-8 decoder select code through enabled lines with a dwell time.
//   Macro DEC_SEL_GRAY_EN (in dec_sel_pkg) switches the sweep order from binary to Gray.
//   clk, rst_n              clock and asynchronous active-low reset
//   start/stop/pause        sweep control (stop wins over everything)
//   oneshot/dir/mask        sweep mode, direction and line enables, captured at start
//   sel/line_idx            decoder code (mirrored bit order) and binary line index
//   sel_valid/busy          sel addresses an enabled line / sequencer in RUN or PAUSE
//   sweep_done              one-cycle pulse at the end of the last enabled line's dwell
module dec_sel_sequencer
    import dec_sel_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       oneshot,
    input  logic       dir,
    input  logic [7:0] mask,
    output logic [2:0] sel,
    output logic [2:0] line_idx,
    output logic       sel_valid,
    output logic       busy,
    output logic       sweep_done
);

    localparam int CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

    state_t        state_q, state_d;
    logic [2:0]    pos_q, pos_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    pmask_q, pmask_d;
    logic          dir_q, dir_d;
    logic          oneshot_q, oneshot_d;
    logic [2:0]    sel_q, sel_d;
    logic [2:0]    line_q, line_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [7:0]    pm_live;
    logic [2:0]    np_pos, np_next, nxt_line;
    logic          np_dir, np_wrap;
    logic [7:0]    np_mask;

    genvar p;
    generate
        for (p = 0; p < 8; p++) begin : g_perm
            assign pm_live[p] = mask[SWEEP_ORDER[p]];
        end
    endgenerate

    // In IDLE the finder starts just outside the table so it returns the first enabled position.
    assign np_pos   = (state_q == IDLE) ? (dir ? 3'd0 : 3'd7) : pos_q;
    assign np_dir   = (state_q == IDLE) ? dir : dir_q;
    assign np_mask  = (state_q == IDLE) ? pm_live : pmask_q;
    assign nxt_line = SWEEP_ORDER[np_next];

    dec_sel_next_pos u_next_pos (
        .pos      (np_pos),
        .dir      (np_dir),
        .pmask    (np_mask),
        .next_pos (np_next),
        .wrap     (np_wrap)
    );

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        cnt_d     = cnt_q;
        pmask_d   = pmask_q;
        dir_d     = dir_q;
        oneshot_d = oneshot_q;
        sel_d     = sel_q;
        line_d    = line_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        if (stop) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
        end else if (state_q == IDLE) begin
            if (start && pm_live != 8'd0) begin
                state_d   = RUN;
                pos_d     = np_next;
                line_d    = nxt_line;
                sel_d     = idx_to_sel(nxt_line);
                cnt_d     = RELOAD;
                pmask_d   = pm_live;
                dir_d     = dir;
                oneshot_d = oneshot;
                valid_d   = 1'b1;
                busy_d    = 1'b1;
            end
        end else if (pause) begin
            state_d = PAUSE;
        end else begin
            // Releasing pause counts on the same edge, so a pause of N cycles extends dwell by N.
            state_d = RUN;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                cnt_d  = RELOAD;
                done_d = np_wrap;
                if (np_wrap && oneshot_q) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    pos_d  = np_next;
                    line_d = nxt_line;
                    sel_d  = idx_to_sel(nxt_line);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pos_q     <= 3'd0;
            cnt_q     <= '0;
            pmask_q   <= 8'd0;
            dir_q     <= 1'b0;
            oneshot_q <= 1'b0;
            sel_q     <= 3'd0;
            line_q    <= 3'd0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            cnt_q     <= cnt_d;
            pmask_q   <= pmask_d;
            dir_q     <= dir_d;
            oneshot_q <= oneshot_d;
            sel_q     <= sel_d;
            line_q    <= line_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign sel        = sel_q;
    assign line_idx   = line_q;
    assign sel_valid  = valid_q;
    assign busy       = busy_q;
    assign sweep_done = done_q;

endmodule

// File: tb/tb_dec_sel_sequencer.sv
// tb_dec_sel_sequencer: directed self-checking bench for dec_sel_sequencer with DWELL=4.
module tb_dec_sel_sequencer;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, pause = 1'b0, oneshot = 1'b0, dir = 1'b0;
    logic [7:0] mask = 8'd0;
    logic [2:0] sel, line_idx;
    logic       sel_valid, busy, sweep_done;
    int         checks = 0, failures = 0;
    logic [8:0] e;

`ifdef DEC_SEL_GRAY_EN
    localparam logic [7:0][2:0] ORD = {3'd4, 3'd5, 3'd7, 3'd6, 3'd2, 3'd3, 3'd1, 3'd0};
`else
    localparam logic [7:0][2:0] ORD = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
`endif

    always #5 clk = ~clk;

    dec_sel_sequencer #(.DWELL(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .oneshot    (oneshot),
        .dir        (dir),
        .mask       (mask),
        .sel        (sel),
        .line_idx   (line_idx),
        .sel_valid  (sel_valid),
        .busy       (busy),
        .sweep_done (sweep_done)
    );

    function automatic logic [2:0] rv(input logic [2:0] l);
        return {l[0], l[1], l[2]};
    endfunction

    // k-th enabled line in sweep order (k counted from the first line of a sweep)
    function automatic logic [2:0] kth(input logic [7:0] m, input logic d, input int k);
        int n = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[ORD[d ? 7 - i : i]]) begin
                if (n == k) return ORD[d ? 7 - i : i];
                n++;
            end
        end
        return 3'd0;
    endfunction

    function automatic logic [8:0] pk(input logic [2:0] l, input logic v, input logic b, input logic d);
        return {l, rv(l), v, b, d};
    endfunction

    function automatic logic [8:0] obs();
        return {line_idx, sel, sel_valid, busy, sweep_done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (obs() !== 9'd0) begin failures++; $display("FAIL reset_async got=%h exp=%h", obs(), 9'd0); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs() !== 9'd0) begin failures++; $display("FAIL reset_idle got=%h exp=%h", obs(), 9'd0); end
    endtask

    task automatic test_mask_zero();
        mask = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (obs() !== 9'd0) begin failures++; $display("FAIL mask0_start got=%h exp=%h", obs(), 9'd0); end
        tick();
        checks++;
        if (obs() !== 9'd0) begin failures++; $display("FAIL mask0_idle got=%h exp=%h", obs(), 9'd0); end
        mask = 8'h10; oneshot = 1'b0; dir = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 13; c++) begin
            e = pk(3'd4, 1'b1, 1'b1, c > 0 && c % 4 == 0);
            checks++;
            if (obs() !== e) begin failures++; $display("FAIL single_line c=%0d got=%h exp=%h", c, obs(), e); end
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        e = pk(3'd4, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL single_stop got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_oneshot();
        logic [2:0] prev;
        mask = 8'hFF; dir = 1'b0; oneshot = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        prev = sel;
        for (int c = 0; c < 32; c++) begin
            e = pk(kth(8'hFF, 1'b0, c / 4), 1'b1, 1'b1, 1'b0);
            checks++;
            if (obs() !== e) begin failures++; $display("FAIL oneshot c=%0d got=%h exp=%h", c, obs(), e); end
`ifdef DEC_SEL_GRAY_EN
            if (c > 0 && c % 4 == 0) begin
                checks++;
                if ($countones(sel ^ prev) != 1) begin failures++; $display("FAIL gray_step c=%0d got=%b prev=%b", c, sel, prev); end
            end
`endif
            prev = sel;
            tick();
        end
        e = pk(ORD[7], 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL oneshot_done got=%h exp=%h", obs(), e); end
        tick();
        e = pk(ORD[7], 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL oneshot_idle got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_continuous();
        mask = 8'hA4; dir = 1'b1; oneshot = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 26; c++) begin
            e = pk(kth(8'hA4, 1'b1, (c / 4) % 3), 1'b1, 1'b1, c > 0 && c % 12 == 0);
            checks++;
            if (obs() !== e) begin failures++; $display("FAIL cont c=%0d got=%h exp=%h", c, obs(), e); end
            if (c == 2) begin mask = 8'hFF; dir = 1'b0; oneshot = 1'b1; start = 1'b1; end
            if (c == 3) start = 1'b0;
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        e = pk(kth(8'hA4, 1'b1, 0), 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL cont_stop got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_pause();
        mask = 8'hFF; dir = 1'b0; oneshot = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        pause = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            e = pk(ORD[0], 1'b1, 1'b1, 1'b0);
            checks++;
            if (obs() !== e) begin failures++; $display("FAIL paused c=%0d got=%h exp=%h", c, obs(), e); end
        end
        pause = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            e = pk(ORD[0], 1'b1, 1'b1, 1'b0);
            checks++;
            if (obs() !== e) begin failures++; $display("FAIL resumed c=%0d got=%h exp=%h", c, obs(), e); end
        end
        tick();
        e = pk(ORD[1], 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL pause_advance got=%h exp=%h", obs(), e); end
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        e = pk(ORD[1], 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL stop_start got=%h exp=%h", obs(), e); end
        tick();
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL stop_idle got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_reset_mid();
        mask = 8'hFF; dir = 1'b0; oneshot = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 9'd0) begin failures++; $display("FAIL reset_mid got=%h exp=%h", obs(), 9'd0); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs() !== 9'd0) begin failures++; $display("FAIL reset_release got=%h exp=%h", obs(), 9'd0); end
    endtask

    initial begin
        test_reset();
        test_mask_zero();
        test_oneshot();
        test_continuous();
        test_pause();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
